// File: rtl/fifo_bram_pkg.sv
// Shared types and helpers for the FIFO-to-BRAM ring writer.
package fifo_bram_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } ring_state_t;

  // Advance a ring address by one word, wrapping at depth-1 back to zero.
  function automatic logic [31:0] ring_next(input logic [31:0] addr, input logic [31:0] depth);
    return (addr == depth - 32'd1) ? 32'd0 : addr + 32'd1;
  endfunction

endpackage

// File: rtl/fifo_bram_ring_writer_fifo.sv
// Single-clock show-ahead FIFO with occupancy count, full/empty flags and a
// synchronous clear. Pushes while full and pops while empty are ignored.
module sync_fifo_flag #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 256
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   clear,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_reg;
  logic [PW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_reg == FULL_COUNT);
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  // Head word is presented without a read cycle so the consumer can pop and
  // capture it on the same edge.
  assign dout    = mem[rd_ptr_reg];

  // Storage write; no reset so the array stays a plain memory.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  // Pointer and occupancy bookkeeping; clear empties the FIFO.
  always_ff @(posedge clk) begin
    if (!rstn || clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (push_ok && !pop_ok) begin
        count_reg <= count_reg + 1'b1;
      end else if (pop_ok && !push_ok) begin
        count_reg <= count_reg - 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_bram_ring_writer.sv
// Buffers wide words with a packet-end flag, serialises each into R BRAM
// beats (low slice first) and writes them into a ring shared with the PS.
// Writing stalls whenever the next write would catch up with the PS read
// pointer, and commit_addr only advances when a packet-end word completes.
module fifo_bram_ring_writer
  import fifo_bram_pkg::*;
#(
  parameter int IN_WIDTH         = 64,
  parameter int BRAM_DATA_WIDTH  = 32,
  parameter int BRAM_ADDR_WIDTH  = 16,
  parameter int BRAM_DEPTH_WORDS = 16384,
  parameter int FIFO_DEPTH       = 256,
  parameter int OVF_CNT_WIDTH    = 16
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic                                enable,
  input  logic                                flush,
  input  logic                                in_valid,
  input  logic [IN_WIDTH-1:0]                 in_data,
  input  logic                                in_last,
  output logic                                in_ready,
  output logic [$clog2(FIFO_DEPTH):0]         fifo_count,
  input  logic [$clog2(BRAM_DEPTH_WORDS)-1:0] ps_read_addr,
  output logic [$clog2(BRAM_DEPTH_WORDS)-1:0] commit_addr,
  output logic [$clog2(BRAM_DEPTH_WORDS):0]   words_available,
  output logic [OVF_CNT_WIDTH-1:0]            overflow_count,
  output logic                                overflow_sticky,
  output logic [BRAM_ADDR_WIDTH-1:0]          bram_addr,
  output logic [BRAM_DATA_WIDTH-1:0]          bram_din,
  output logic                                bram_en,
  output logic [BRAM_DATA_WIDTH/8-1:0]        bram_we,
  output logic                                bram_clk,
  output logic                                bram_rst
);
  localparam int R          = IN_WIDTH / BRAM_DATA_WIDTH;
  localparam int AW         = $clog2(BRAM_DEPTH_WORDS);
  localparam int AW1        = AW + 1;
  localparam int BW         = (R > 1) ? $clog2(R) : 1;
  localparam int BYTE_SHIFT = $clog2(BRAM_DATA_WIDTH / 8);
  localparam logic [BW-1:0] LAST_BEAT = BW'(R - 1);
  localparam logic [AW:0]   DEPTH_W   = AW1'(BRAM_DEPTH_WORDS);

  ring_state_t                state_reg, state_next;
  logic [BW-1:0]              beat_reg, beat_next;
  logic [AW-1:0]              wr_addr_reg, wr_addr_next;
  logic [AW-1:0]              commit_reg, commit_next;
  logic [IN_WIDTH-1:0]        hold_data_reg, hold_data_next;
  logic                       hold_last_reg, hold_last_next;
  logic                       bram_en_reg, bram_en_next;
  logic [BRAM_ADDR_WIDTH-1:0] bram_addr_reg, bram_addr_next;
  logic [BRAM_DATA_WIDTH-1:0] bram_din_reg, bram_din_next;
  logic [OVF_CNT_WIDTH-1:0]   ovf_cnt_reg;
  logic                       sticky_reg;

  logic [IN_WIDTH:0]          fifo_dout;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic                       fifo_pop;
  logic                       drop;
  logic                       can_pop;
  logic                       space;
  logic [AW-1:0]              wr_inc;
  logic [AW:0]                avail_diff;
  logic [BRAM_DATA_WIDTH-1:0] beat_slice [R];

  sync_fifo_flag #(
    .WIDTH (IN_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .clear (flush),
    .push  (in_valid),
    .pop   (fifo_pop),
    .din   ({in_last, in_data}),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Split the held word into BRAM-width beats, beat 0 in the low bits.
  generate
    for (genvar gi = 0; gi < R; gi++) begin : g_slice
      assign beat_slice[gi] = hold_data_reg[gi*BRAM_DATA_WIDTH +: BRAM_DATA_WIDTH];
    end
  endgenerate

  assign drop    = in_valid && fifo_full;
  assign can_pop = enable && !fifo_empty;
  assign wr_inc  = AW'(ring_next(32'(wr_addr_reg), 32'(BRAM_DEPTH_WORDS)));
  // Keep one slot free so a full ring is never mistaken for an empty one.
  assign space   = (wr_inc != ps_read_addr);

  // Next-state, beat issue and pop decision; a word is never abandoned
  // because enable drops, only when flush or reset arrives.
  always_comb begin
    state_next     = state_reg;
    beat_next      = beat_reg;
    wr_addr_next   = wr_addr_reg;
    commit_next    = commit_reg;
    hold_data_next = hold_data_reg;
    hold_last_next = hold_last_reg;
    bram_en_next   = 1'b0;
    bram_addr_next = bram_addr_reg;
    bram_din_next  = bram_din_reg;
    fifo_pop       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (can_pop) begin
          fifo_pop       = 1'b1;
          hold_data_next = fifo_dout[IN_WIDTH-1:0];
          hold_last_next = fifo_dout[IN_WIDTH];
          beat_next      = '0;
          state_next     = WRITE;
        end
      end
      WRITE: begin
        if (space) begin
          bram_en_next   = 1'b1;
          bram_addr_next = BRAM_ADDR_WIDTH'(wr_addr_reg) << BYTE_SHIFT;
          bram_din_next  = beat_slice[beat_reg];
          wr_addr_next   = wr_inc;
          if (beat_reg == LAST_BEAT) begin
            beat_next = '0;
            if (hold_last_reg) begin
              commit_next = wr_inc;
            end
            // Chain straight into the next word to sustain one beat per cycle.
            if (can_pop) begin
              fifo_pop       = 1'b1;
              hold_data_next = fifo_dout[IN_WIDTH-1:0];
              hold_last_next = fifo_dout[IN_WIDTH];
            end else begin
              state_next = IDLE;
            end
          end else begin
            beat_next = beat_reg + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State registers; flush rewinds the write pointer to the last commit and
  // clears drop accounting, reset clears everything.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg     <= IDLE;
      beat_reg      <= '0;
      wr_addr_reg   <= '0;
      commit_reg    <= '0;
      hold_data_reg <= '0;
      hold_last_reg <= 1'b0;
      bram_en_reg   <= 1'b0;
      bram_addr_reg <= '0;
      bram_din_reg  <= '0;
      ovf_cnt_reg   <= '0;
      sticky_reg    <= 1'b0;
    end else if (flush) begin
      state_reg     <= IDLE;
      beat_reg      <= '0;
      wr_addr_reg   <= commit_reg;
      hold_data_reg <= '0;
      hold_last_reg <= 1'b0;
      bram_en_reg   <= 1'b0;
      bram_addr_reg <= '0;
      bram_din_reg  <= '0;
      ovf_cnt_reg   <= '0;
      sticky_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      beat_reg      <= beat_next;
      wr_addr_reg   <= wr_addr_next;
      commit_reg    <= commit_next;
      hold_data_reg <= hold_data_next;
      hold_last_reg <= hold_last_next;
      bram_en_reg   <= bram_en_next;
      bram_addr_reg <= bram_addr_next;
      bram_din_reg  <= bram_din_next;
      if (drop) begin
        sticky_reg <= 1'b1;
        if (ovf_cnt_reg != '1) begin
          ovf_cnt_reg <= ovf_cnt_reg + 1'b1;
        end
      end
    end
  end

  // Unread span between PS pointer and commit point, modulo ring depth.
  assign avail_diff      = {1'b0, commit_reg} - {1'b0, ps_read_addr};
  assign words_available = avail_diff[AW] ? avail_diff + DEPTH_W : avail_diff;

  assign in_ready        = !fifo_full;
  assign commit_addr     = commit_reg;
  assign overflow_count  = ovf_cnt_reg;
  assign overflow_sticky = sticky_reg;
  assign bram_addr       = bram_addr_reg;
  assign bram_din        = bram_din_reg;
  assign bram_en         = bram_en_reg;
  assign bram_we         = {(BRAM_DATA_WIDTH/8){bram_en_reg}};
  assign bram_clk        = clk;
  assign bram_rst        = ~rstn;

endmodule

// File: tb/tb_fifo_bram_ring_writer.sv
// Self-checking bench for fifo_bram_ring_writer: directed scenarios plus a
// randomized phase, with a word-queue reference model of the ring contents.
module tb_fifo_bram_ring_writer;
  localparam int IW    = 64;
  localparam int DW    = 32;
  localparam int AWB   = 16;
  localparam int DEPTH = 16;
  localparam int FD    = 8;
  localparam int OW    = 3;
  localparam int R     = IW / DW;
  localparam int AW    = 4;
  localparam int FCW   = 4;

  logic           clk = 1'b0;
  logic           rstn = 1'b0;
  logic           enable = 1'b0;
  logic           flush = 1'b0;
  logic           in_valid = 1'b0;
  logic [IW-1:0]  in_data = '0;
  logic           in_last = 1'b0;
  logic           in_ready;
  logic [FCW-1:0] fifo_count;
  logic [AW-1:0]  ps_read_addr = '0;
  logic [AW-1:0]  commit_addr;
  logic [AW:0]    words_available;
  logic [OW-1:0]  overflow_count;
  logic           overflow_sticky;
  logic [AWB-1:0] bram_addr;
  logic [DW-1:0]  bram_din;
  logic           bram_en;
  logic [3:0]     bram_we;
  logic           bram_clk;
  logic           bram_rst;

  fifo_bram_ring_writer #(
    .IN_WIDTH(IW), .BRAM_DATA_WIDTH(DW), .BRAM_ADDR_WIDTH(AWB),
    .BRAM_DEPTH_WORDS(DEPTH), .FIFO_DEPTH(FD), .OVF_CNT_WIDTH(OW)
  ) dut (
    .clk(clk), .rstn(rstn), .enable(enable), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .fifo_count(fifo_count), .ps_read_addr(ps_read_addr),
    .commit_addr(commit_addr), .words_available(words_available),
    .overflow_count(overflow_count), .overflow_sticky(overflow_sticky),
    .bram_addr(bram_addr), .bram_din(bram_din), .bram_en(bram_en),
    .bram_we(bram_we), .bram_clk(bram_clk), .bram_rst(bram_rst)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: accepted words awaiting write, ring write/commit points.
  logic [IW-1:0] q_data[$];
  logic          q_last[$];
  int            beat_idx   = 0;
  int            m_wr       = 0;
  int            m_commit   = 0;
  int            beats_seen = 0;
  int            en_run     = 0;
  int            en_run_max = 0;
  bit            mon_on     = 0;
  logic [AW-1:0] rd_prev    = '0;

  always @(posedge clk) rd_prev = ps_read_addr;

  // Every issued beat must be the next slice of the oldest pending word at
  // the next ring address, and must not fill the last free slot.
  always @(negedge clk) begin : monitor
    logic [IW-1:0] w;
    if (rstn && mon_on) begin
      if (bram_en) begin
        beats_seen++;
        en_run++;
        if (en_run > en_run_max) en_run_max = en_run;
        if (q_data.size() == 0) begin
          check_val("unexpected_beat", 64'd1, 64'd0);
        end else begin
          w = q_data[0];
          check_val("bram_addr", bram_addr, 64'(m_wr * 4));
          check_val("bram_din", bram_din, w[beat_idx*DW +: DW]);
          check_val("bram_we", bram_we, 64'hF);
          check_val("no_overrun", ((m_wr + 1) % DEPTH) != int'(rd_prev), 64'd1);
          m_wr = (m_wr + 1) % DEPTH;
          beat_idx++;
          if (beat_idx == R) begin
            beat_idx = 0;
            if (q_last[0]) m_commit = m_wr;
            void'(q_data.pop_front());
            void'(q_last.pop_front());
          end
        end
      end else begin
        en_run = 0;
      end
      check_val("commit_addr", commit_addr, 64'(m_commit));
      check_val("words_available", words_available,
                64'((m_commit - int'(ps_read_addr) + DEPTH) % DEPTH));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [IW-1:0] d, input logic l);
    check_val("in_ready", in_ready, 64'd1);
    in_valid = 1'b1; in_data = d; in_last = l;
    tick(1);
    in_valid = 1'b0;
    q_data.push_back(d);
    q_last.push_back(l);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    q_data.delete(); q_last.delete();
    beat_idx = 0;
    m_wr = m_commit;
  endtask

  task automatic wait_drain(input int budget, input string tag);
    int n = 0;
    while (q_data.size() != 0 && n < budget) begin
      tick(1);
      n++;
    end
    check_val(tag, 64'(q_data.size()), 64'd0);
  endtask

  task automatic sample_en(input string tag, input logic exp);
    @(negedge clk);
    check_val(tag, bram_en, 64'(exp));
  endtask

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_in_ready"}, in_ready, 64'd1);
    check_val({tag, "_fifo_count"}, fifo_count, 64'd0);
    check_val({tag, "_commit"}, commit_addr, 64'd0);
    check_val({tag, "_bram_en"}, bram_en, 64'd0);
    check_val({tag, "_bram_rst"}, bram_rst, 64'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int b0;
    logic [IW-1:0] d;

    // Reset state
    tick(3);
    check_idle_outputs("reset");
    check_val("reset_avail", words_available, 64'd0);
    check_val("reset_ovf", overflow_count, 64'd0);
    check_val("reset_sticky", overflow_sticky, 64'd0);
    check_val("reset_addr", bram_addr, 64'd0);
    check_val("reset_din", bram_din, 64'd0);
    rstn = 1'b1; enable = 1'b1; mon_on = 1;
    tick(1);
    check_val("bram_rst_run", bram_rst, 64'd0);

    // Three-word packet: beats 0..5, commit only after the last beat
    for (int i = 0; i < 3; i++) push({$urandom, $urandom}, i == 2);
    wait_drain(40, "t1_drain");
    tick(2);
    check_val("t1_commit", commit_addr, 64'd6);

    // Latency: push at E0 -> first bram_en after E0+2
    push({$urandom, $urandom}, 1'b1);
    sample_en("lat_e0", 1'b0);
    sample_en("lat_e1", 1'b0);
    sample_en("lat_e2", 1'b1);
    sample_en("lat_e3", 1'b1);
    sample_en("lat_e4", 1'b0);
    tick(1);

    // Wrap and stall against the PS pointer, mid-word stall then resume
    ps_read_addr = 4'd4;
    b0 = beats_seen;
    for (int i = 0; i < 6; i++) push({$urandom, $urandom}, i == 5);
    tick(30);
    check_val("t2_stall_beats", 64'(beats_seen - b0), 64'd11);
    check_val("t2_stall_commit", commit_addr, 64'd8);
    check_val("t2_stall_en", bram_en, 64'd0);
    check_val("t2_stall_fifo", fifo_count, 64'd0);
    ps_read_addr = 4'd10;
    wait_drain(40, "t2_drain");
    tick(2);
    check_val("t2_commit", commit_addr, 64'd4);
    check_val("t2_avail", words_available, 64'd10);

    // Overflow with draining disabled, saturation, then flush
    enable = 1'b0;
    for (int i = 0; i < FD + 9; i++) begin
      check_val("t3_in_ready", in_ready, 64'(i < FD));
      d = {$urandom, $urandom};
      in_valid = 1'b1; in_data = d; in_last = 1'b0;
      tick(1);
      in_valid = 1'b0;
      if (i < FD) begin q_data.push_back(d); q_last.push_back(1'b0); end
      if (i == FD + 4) begin
        check_val("t3_ovf5", overflow_count, 64'd5);
        check_val("t3_sticky", overflow_sticky, 64'd1);
      end
    end
    check_val("t3_fifo_full", fifo_count, 64'(FD));
    check_val("t3_ovf_sat", overflow_count, 64'd7);
    do_flush();
    check_val("t3_flush_fifo", fifo_count, 64'd0);
    check_val("t3_flush_ready", in_ready, 64'd1);
    check_val("t3_flush_ovf", overflow_count, 64'd0);
    check_val("t3_flush_sticky", overflow_sticky, 64'd0);
    check_val("t3_flush_commit", commit_addr, 64'd4);
    enable = 1'b1;

    // Flush mid-packet: two of four words written, then rewind
    ps_read_addr = 4'd9;
    b0 = beats_seen;
    for (int i = 0; i < 4; i++) push({$urandom, $urandom}, i == 3);
    tick(20);
    check_val("t5_partial_beats", 64'(beats_seen - b0), 64'd4);
    do_flush();
    check_val("t5_commit_kept", commit_addr, 64'd4);
    check_val("t5_fifo_clear", fifo_count, 64'd0);
    ps_read_addr = 4'd0;
    for (int i = 0; i < 2; i++) push({$urandom, $urandom}, i == 1);
    wait_drain(30, "t5_drain");
    tick(2);
    check_val("t5_commit", commit_addr, 64'd8);

    // Enable dropped during a word: that word completes, rest stays queued
    b0 = beats_seen;
    for (int i = 0; i < 3; i++) push({$urandom, $urandom}, i == 2);
    enable = 1'b0;
    tick(10);
    check_val("t6_beats", 64'(beats_seen - b0), 64'd2);
    check_val("t6_fifo_held", fifo_count, 64'd2);
    check_val("t6_en_idle", bram_en, 64'd0);
    enable = 1'b1;
    wait_drain(30, "t6_drain");
    tick(2);
    check_val("t6_commit", commit_addr, 64'd14);

    // Sustained rate: one word per R cycles gives an unbroken beat stream
    en_run_max = 0;
    for (int i = 0; i < 20; i++) begin
      ps_read_addr = 4'((m_wr + 8) % DEPTH);
      push({$urandom, $urandom}, i == 19);
      check_val("t4_fifo_le2", fifo_count <= 2, 64'd1);
      ps_read_addr = 4'((m_wr + 8) % DEPTH);
      tick(1);
      check_val("t4_fifo_le2", fifo_count <= 2, 64'd1);
    end
    ps_read_addr = 4'((m_wr + 8) % DEPTH);
    wait_drain(30, "t4_drain");
    check_val("t4_run", 64'(en_run_max), 64'd40);

    // Randomized traffic, enable, PS pointer and occasional flush
    for (int c = 0; c < 300; c++) begin
      enable = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 7) == 0) ps_read_addr = 4'($urandom_range(0, DEPTH - 1));
      if ($urandom_range(0, 59) == 0) begin
        do_flush();
      end else if (q_data.size() < 6 && $urandom_range(0, 2) != 0) begin
        push({$urandom, $urandom}, $urandom_range(0, 3) == 0);
      end else begin
        tick(1);
      end
    end
    enable = 1'b1;
    ps_read_addr = 4'(m_wr);
    wait_drain(200, "rand_drain");
    tick(3);

    // Reset in the middle of a packet: no further writes afterwards
    ps_read_addr = 4'((m_wr + 8) % DEPTH);
    for (int i = 0; i < 3; i++) push({$urandom, $urandom}, i == 2);
    rstn = 1'b0;
    tick(1);
    check_idle_outputs("midrst");
    q_data.delete(); q_last.delete();
    beat_idx = 0; m_wr = 0; m_commit = 0;
    ps_read_addr = 4'd0;
    rstn = 1'b1;
    b0 = beats_seen;
    tick(6);
    check_val("midrst_no_beats", 64'(beats_seen - b0), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
